// File: rtl/turf_hdr_pkg.sv
// Shared constants and types for the TURF event-header generator and checker.
package turf_hdr_pkg;

   localparam int          NUM_QWORDS   = 16;
   localparam logic [15:0] HDR_WORDS    = 16'd63;
   localparam logic [15:0] EVENT_FORMAT = 16'h4531;
   localparam logic [15:0] SURF_WORDS   = 16'd64;

   localparam int QW_EVENT   = 0;
   localparam int QW_TIME    = 1;
   localparam int QW_PPS     = 2;
   localparam int QW_TRAILER = 15;

   typedef enum int unsigned {
      ERR_FORMAT = 0,
      ERR_SEQ    = 1,
      ERR_SHORT  = 2,
      ERR_LONG   = 3
   } err_bit_e;

   typedef enum logic [0:0] {
      ST_HDR   = 1'b0,
      ST_DRAIN = 1'b1
   } chk_state_e;

endpackage

// File: rtl/turf_header_chk_ila.sv
// Debug capture of checker state, beat index and error flags.
module turf_header_chk_ila (
   input logic       clk,
   input logic [0:0] probe_state,
   input logic [3:0] probe_beat,
   input logic [3:0] probe_err
);

   logic [8:0] sample_r;

   // Register probes so the capture core sees a clean timing path.
   always_ff @(posedge clk) begin
      sample_r <= {probe_state, probe_beat, probe_err};
   end

endmodule

// File: rtl/turf_header_checker.sv
// Pass-through monitor for the TURF event-header stream: checks framing, format and
// event sequence, and latches decoded header fields.
module turf_header_checker
   import turf_hdr_pkg::*;
#(
   parameter int          NUM_QWORDS   = turf_hdr_pkg::NUM_QWORDS,
   parameter logic [15:0] HDR_WORDS    = turf_hdr_pkg::HDR_WORDS,
   parameter logic [15:0] EVENT_FORMAT = turf_hdr_pkg::EVENT_FORMAT,
   parameter logic [15:0] SURF_WORDS   = turf_hdr_pkg::SURF_WORDS,
   parameter string       DEBUG        = "FALSE"
) (
   input  logic        memclk,
   input  logic        memrst,
   input  logic [63:0] s_thdr_tdata,
   input  logic        s_thdr_tvalid,
   output logic        s_thdr_tready,
   input  logic        s_thdr_tlast,
   output logic [63:0] m_thdr_tdata,
   output logic        m_thdr_tvalid,
   output logic        m_thdr_tlast,
   input  logic        m_thdr_tready,
   input  logic        cnt_clr_i,
   output logic        hdr_valid_o,
   output logic [31:0] hdr_event_o,
   output logic [31:0] hdr_sec_o,
   output logic [31:0] hdr_time_o,
   output logic [31:0] hdr_last_pps_o,
   output logic [31:0] hdr_llast_pps_o,
   output logic [11:0] hdr_runcfg_o,
   output logic [3:0]  hdr_tio_mask_o,
   output logic [3:0]  hdr_err_o,
   output logic [31:0] hdr_count_o,
   output logic [15:0] err_count_o
);

   localparam int               IDX_W    = $clog2(NUM_QWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_QWORDS - 1);

   assign m_thdr_tdata  = s_thdr_tdata;
   assign m_thdr_tvalid = s_thdr_tvalid;
   assign m_thdr_tlast  = s_thdr_tlast;
   assign s_thdr_tready = m_thdr_tready;

   chk_state_e       state_r, state_n;
   logic [IDX_W-1:0] idx_r, idx_n;
   logic [3:0]       err_r, err_n;
   logic [31:0]      expected_r;
   logic             first_hdr_r;
   logic             beat, complete, cap_event, cap_time, cap_pps, cap_trailer;

   assign beat = s_thdr_tvalid && m_thdr_tready;

   // Next-state, beat index and per-header error accumulation.
   always_comb begin
      state_n     = state_r;
      idx_n       = idx_r;
      err_n       = err_r;
      complete    = 1'b0;
      cap_event   = 1'b0;
      cap_time    = 1'b0;
      cap_pps     = 1'b0;
      cap_trailer = 1'b0;
      if (beat) begin
         case (state_r)
            ST_HDR: begin
               if (idx_r == IDX_W'(QW_EVENT)) begin
                  err_n             = 4'b0000;
                  err_n[ERR_FORMAT] = (s_thdr_tdata[31:0] != {EVENT_FORMAT, HDR_WORDS});
                  err_n[ERR_SEQ]    = !first_hdr_r && (s_thdr_tdata[63:32] != expected_r);
                  cap_event         = 1'b1;
               end else begin
                  cap_time = (idx_r == IDX_W'(QW_TIME));
                  cap_pps  = (idx_r == IDX_W'(QW_PPS));
               end
               if (idx_r == LAST_IDX) begin
                  if (s_thdr_tlast) begin
                     err_n[ERR_FORMAT] = err_n[ERR_FORMAT] | (s_thdr_tdata[63:48] != SURF_WORDS);
                     cap_trailer       = 1'b1;
                     complete          = 1'b1;
                     idx_n             = '0;
                  end else begin
                     // Missing tlast: swallow the rest of this frame before resyncing.
                     err_n[ERR_LONG] = 1'b1;
                     state_n         = ST_DRAIN;
                     idx_n           = '0;
                  end
               end else if (s_thdr_tlast) begin
                  err_n[ERR_SHORT] = 1'b1;
                  complete         = 1'b1;
                  idx_n            = '0;
               end else begin
                  idx_n = idx_r + IDX_W'(1);
               end
            end
            ST_DRAIN: begin
               if (s_thdr_tlast) begin
                  complete = 1'b1;
                  state_n  = ST_HDR;
               end else begin
                  state_n = ST_DRAIN;
               end
            end
            default: begin
               state_n = ST_HDR;
               idx_n   = '0;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // State, captured fields, completion pulse and counters.
   always_ff @(posedge memclk) begin
      if (memrst) begin
         state_r         <= ST_HDR;
         idx_r           <= '0;
         err_r           <= 4'b0000;
         expected_r      <= 32'h0000_0000;
         first_hdr_r     <= 1'b1;
         hdr_valid_o     <= 1'b0;
         hdr_event_o     <= 32'h0000_0000;
         hdr_sec_o       <= 32'h0000_0000;
         hdr_time_o      <= 32'h0000_0000;
         hdr_last_pps_o  <= 32'h0000_0000;
         hdr_llast_pps_o <= 32'h0000_0000;
         hdr_runcfg_o    <= 12'h000;
         hdr_tio_mask_o  <= 4'h0;
         hdr_err_o       <= 4'b0000;
         hdr_count_o     <= 32'h0000_0000;
         err_count_o     <= 16'h0000;
      end else begin
         state_r     <= state_n;
         idx_r       <= idx_n;
         err_r       <= err_n;
         hdr_valid_o <= complete;
         if (cap_event) begin
            hdr_event_o <= s_thdr_tdata[63:32];
            expected_r  <= s_thdr_tdata[63:32] + 32'd1;
            first_hdr_r <= 1'b0;
         end
         if (cap_time) begin
            hdr_sec_o  <= s_thdr_tdata[31:0];
            hdr_time_o <= s_thdr_tdata[63:32];
         end
         if (cap_pps) begin
            hdr_last_pps_o  <= s_thdr_tdata[31:0];
            hdr_llast_pps_o <= s_thdr_tdata[63:32];
         end
         if (cap_trailer) begin
            hdr_runcfg_o   <= s_thdr_tdata[43:32];
            hdr_tio_mask_o <= s_thdr_tdata[47:44];
         end
         if (complete) begin
            hdr_err_o <= err_n;
         end
         // Clear outranks a same-cycle completion and re-arms the first-header flag.
         if (cnt_clr_i) begin
            hdr_count_o <= 32'h0000_0000;
            err_count_o <= 16'h0000;
            first_hdr_r <= 1'b1;
         end else if (complete) begin
            hdr_count_o <= hdr_count_o + 32'd1;
            if ((err_n != 4'b0000) && (err_count_o != 16'hFFFF)) begin
               err_count_o <= err_count_o + 16'd1;
            end
         end
      end
   end

   generate
      if (DEBUG == "TRUE") begin : g_ila
         turf_header_chk_ila u_ila (
            .clk         (memclk),
            .probe_state (state_r),
            .probe_beat  (4'(idx_r)),
            .probe_err   (err_r)
         );
      end
   endgenerate

endmodule

// File: tb/tb_turf_header_checker.sv
// Scoreboard bench: header tasks push expected completions, a negedge monitor pops and compares.
module tb_turf_header_checker;

   logic        memclk = 1'b0;
   logic        memrst = 1'b1;
   logic [63:0] s_thdr_tdata = 64'h0;
   logic        s_thdr_tvalid = 1'b0;
   logic        s_thdr_tready;
   logic        s_thdr_tlast = 1'b0;
   logic [63:0] m_thdr_tdata;
   logic        m_thdr_tvalid;
   logic        m_thdr_tlast;
   logic        m_thdr_tready = 1'b1;
   logic        cnt_clr_i = 1'b0;
   logic        hdr_valid_o;
   logic [31:0] hdr_event_o, hdr_sec_o, hdr_time_o, hdr_last_pps_o, hdr_llast_pps_o;
   logic [11:0] hdr_runcfg_o;
   logic [3:0]  hdr_tio_mask_o, hdr_err_o;
   logic [31:0] hdr_count_o;
   logic [15:0] err_count_o;

   turf_header_checker dut (
      .memclk(memclk), .memrst(memrst),
      .s_thdr_tdata(s_thdr_tdata), .s_thdr_tvalid(s_thdr_tvalid),
      .s_thdr_tready(s_thdr_tready), .s_thdr_tlast(s_thdr_tlast),
      .m_thdr_tdata(m_thdr_tdata), .m_thdr_tvalid(m_thdr_tvalid),
      .m_thdr_tlast(m_thdr_tlast), .m_thdr_tready(m_thdr_tready),
      .cnt_clr_i(cnt_clr_i), .hdr_valid_o(hdr_valid_o),
      .hdr_event_o(hdr_event_o), .hdr_sec_o(hdr_sec_o), .hdr_time_o(hdr_time_o),
      .hdr_last_pps_o(hdr_last_pps_o), .hdr_llast_pps_o(hdr_llast_pps_o),
      .hdr_runcfg_o(hdr_runcfg_o), .hdr_tio_mask_o(hdr_tio_mask_o),
      .hdr_err_o(hdr_err_o), .hdr_count_o(hdr_count_o), .err_count_o(err_count_o)
   );

   always #5 memclk = ~memclk;

   typedef struct {
      logic [3:0]  err;
      logic [31:0] ev, sec, tm, lpps, llpps;
      logic [11:0] runcfg;
      logic [3:0]  tio;
      logic [31:0] hcnt;
      logic [15:0] ecnt;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [31:0] m_sec, m_tm, m_lpps, m_llpps, m_hcnt;
   logic [11:0] m_runcfg;
   logic [3:0]  m_tio;
   logic [15:0] m_ecnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] qword(input logic [31:0] ev, input int i,
                                         input logic [15:0] hw, input logic [15:0] surf);
      logic [11:0] rc;
      rc = 12'h123 + ev[11:0];
      case (i)
         0:       return {ev, 16'h4531, hw};
         1:       return {ev + 32'd100, ev ^ 32'h1111_0000};
         2:       return {ev + 32'd7, ev ^ 32'h5555_0000};
         15:      return {surf, 4'hA, rc, 32'h0000_0000};
         default: return {32'hDEAD_0000 | 32'(i), ev};
      endcase
   endfunction

   // Completion monitor plus bit-exact pass-through check.
   always @(negedge memclk) begin
      if (!memrst) begin
         check("pass_data", m_thdr_tdata, s_thdr_tdata);
         check("pass_ctl", {61'h0, m_thdr_tvalid, m_thdr_tlast, s_thdr_tready},
               {61'h0, s_thdr_tvalid, s_thdr_tlast, m_thdr_tready});
      end
      if (hdr_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(hdr_valid_o), 64'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("err", 64'(hdr_err_o), 64'(e.err));
            check("event", 64'(hdr_event_o), 64'(e.ev));
            check("sec_time", {hdr_time_o, hdr_sec_o}, {e.tm, e.sec});
            check("pps", {hdr_llast_pps_o, hdr_last_pps_o}, {e.llpps, e.lpps});
            check("runcfg_tio", {48'h0, hdr_tio_mask_o, hdr_runcfg_o}, {48'h0, e.tio, e.runcfg});
            check("hdr_count", 64'(hdr_count_o), 64'(e.hcnt));
            check("err_count", 64'(err_count_o), 64'(e.ecnt));
         end
      end
   end

   task automatic model_reset();
      m_sec = 0; m_tm = 0; m_lpps = 0; m_llpps = 0; m_runcfg = 0; m_tio = 0;
      m_hcnt = 0; m_ecnt = 0;
   endtask

   task automatic do_reset();
      @(negedge memclk);
      memrst = 1'b1; s_thdr_tvalid = 1'b0; s_thdr_tlast = 1'b0; m_thdr_tready = 1'b1;
      model_reset();
      repeat (2) @(negedge memclk);
      memrst = 1'b0;
      check("rst_valid_err", {59'h0, hdr_valid_o, hdr_err_o}, 64'h0);
      check("rst_counts", {16'h0, err_count_o, hdr_count_o}, 64'h0);
      check("rst_fields", {hdr_event_o, 16'h0, hdr_tio_mask_o, hdr_runcfg_o}, 64'h0);
   endtask

   task automatic clr_pulse();
      @(negedge memclk);
      cnt_clr_i = 1'b1;
      @(negedge memclk);
      cnt_clr_i = 1'b0;
      m_hcnt = 0; m_ecnt = 0;
   endtask

   task automatic send_hdr(input logic [31:0] ev, input int nbeats, input logic [15:0] hw,
                           input logic [15:0] surf, input bit rnd, input bit clr_last,
                           input bit abort, input logic [3:0] err_exp);
      exp_t e;
      int   guard;
      for (int i = 0; i < nbeats; i++) begin
         @(negedge memclk);
         s_thdr_tvalid = 1'b1;
         s_thdr_tdata  = qword(ev, i, hw, surf);
         s_thdr_tlast  = !abort && (i == nbeats - 1);
         cnt_clr_i     = clr_last && s_thdr_tlast;
         if (i == 1) begin m_sec = ev ^ 32'h1111_0000; m_tm = ev + 32'd100; end
         if (i == 2) begin m_lpps = ev ^ 32'h5555_0000; m_llpps = ev + 32'd7; end
         if (i == 15 && nbeats == 16) begin m_runcfg = 12'h123 + ev[11:0]; m_tio = 4'hA; end
         if (s_thdr_tlast) begin
            if (clr_last) begin
               m_hcnt = 0; m_ecnt = 0;
            end else begin
               m_hcnt = m_hcnt + 1;
               if (err_exp != 4'b0000 && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 1;
            end
            e.err = err_exp; e.ev = ev; e.sec = m_sec; e.tm = m_tm; e.lpps = m_lpps;
            e.llpps = m_llpps; e.runcfg = m_runcfg; e.tio = m_tio; e.hcnt = m_hcnt; e.ecnt = m_ecnt;
            exp_q.push_back(e);
         end
         guard = 0;
         m_thdr_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge memclk);
         while (!m_thdr_tready) begin
            @(negedge memclk);
            guard++;
            m_thdr_tready = (rnd && guard < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge memclk);
         end
      end
      @(negedge memclk);
      s_thdr_tvalid = 1'b0; s_thdr_tlast = 1'b0; cnt_clr_i = 1'b0; m_thdr_tready = 1'b1;
   endtask

   initial begin
      do_reset();
      send_hdr(32'd0, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      clr_pulse();
      send_hdr(32'd5, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd7, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0010);
      send_hdr(32'd8, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd9, 10, 16'd63, 16'h0040, 0, 0, 0, 4'b0100);
      send_hdr(32'd10, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd11, 20, 16'd63, 16'h0040, 0, 0, 0, 4'b1000);
      send_hdr(32'd12, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd13, 16, 16'd62, 16'h0040, 1, 0, 0, 4'b0001);
      send_hdr(32'd14, 16, 16'd63, 16'h0041, 0, 0, 0, 4'b0001);
      send_hdr(32'd15, 16, 16'd63, 16'h0040, 1, 0, 0, 4'b0000);
      send_hdr(32'd16, 7, 16'd63, 16'h0040, 0, 0, 1, 4'b0000);
      do_reset();
      send_hdr(32'hFFFF_FFFF, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd0, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      send_hdr(32'd1, 16, 16'd63, 16'h0040, 0, 1, 0, 4'b0000);
      send_hdr(32'd50, 16, 16'd63, 16'h0040, 0, 0, 0, 4'b0000);
      repeat (4) @(negedge memclk);
      check("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
